// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: word/address widths,
// fetch FSM encoding and the address range helper.
package imem_pkg;

    localparam int WORD_W      = 32;
    localparam int BYTE_ADDR_W = 20;

    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FILL = 2'd2
    } fetch_state_t;

    // True when the byte address falls inside a store of 2**addr_w words.
    function automatic logic addr_in_range(input logic [BYTE_ADDR_W-1:0] byte_addr,
                                           input int unsigned            addr_w);
        return (byte_addr >> (addr_w + 2)) == '0;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Program store: DEPTH x 32 words, synchronous write and enabled synchronous read.
// Contents are never reset; only the read register is.
module imem_array import imem_pkg::*; #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WORD_W-1:0] write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [WORD_W-1:0] read_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    // A same-edge write to the word being read is forwarded so the reader sees the new data.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            read_data <= '0;
        end else if (read_en) begin
            if (write_en && (write_addr == read_addr)) begin
                read_data <= write_data;
            end else begin
                read_data <= mem[read_addr];
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one-word fetch buffer in front of a slow program store,
// with a loader write port that is accepted whenever the fill FSM is idle.
module imem_responder import imem_pkg::*; #(
    parameter int                ADDR_W      = 10,
    parameter int                WAIT_STATES = 2,
    parameter logic [WORD_W-1:0] FAULT_WORD  = NOP_WORD
) (
    input  logic                   clock,
    input  logic                   nReset,
    input  logic [BYTE_ADDR_W-1:0] IMemAddr,
    output logic [WORD_W-1:0]      IMemDataOut,
    output logic                   IMemStall,
    output logic                   IMemFault,
    input  logic                   LoadValid,
    output logic                   LoadReady,
    input  logic [BYTE_ADDR_W-1:0] LoadAddr,
    input  logic [WORD_W-1:0]      LoadData
);

    localparam int WORD_ADDR_W = BYTE_ADDR_W - 2;

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("imem_responder: WAIT_STATES must be in 0..15");
    end
    if (ADDR_W < 1 || ADDR_W > WORD_ADDR_W) begin : g_bad_addr_w
        $error("imem_responder: ADDR_W must be in 1..18");
    end

    // The miss cycle and the FILL cycle are both stall cycles, so WAIT lasts WAIT_STATES-1.
    localparam logic [3:0] WAIT_RELOAD = 4'(WAIT_STATES - 1);

    fetch_state_t           state;
    logic [3:0]             cnt;
    logic                   buf_valid;
    logic [WORD_ADDR_W-1:0] buf_addr;
    logic                   buf_fault;
    logic [WORD_ADDR_W-1:0] req_addr;

    logic [WORD_ADDR_W-1:0] fetch_word;
    logic [WORD_ADDR_W-1:0] load_word;
    logic                   fetch_in_range;
    logic                   load_in_range;
    logic                   hit;
    logic                   load_fire;
    logic                   fill_now;
    logic                   array_read_en;
    logic                   array_write_en;
    logic [WORD_W-1:0]      array_data;
    logic                   unused_bits;

    assign fetch_word     = IMemAddr[BYTE_ADDR_W-1:2];
    assign load_word      = LoadAddr[BYTE_ADDR_W-1:2];
    assign fetch_in_range = addr_in_range(IMemAddr, ADDR_W);
    assign load_in_range  = addr_in_range(LoadAddr, ADDR_W);
    assign unused_bits    = ^{IMemAddr[1:0], LoadAddr[1:0]};

    assign hit       = buf_valid && (buf_addr == fetch_word);
    assign load_fire = LoadValid && (state == IDLE);

    // With zero wait states the miss cycle itself performs the array read.
    assign fill_now       = (state == FILL) ||
                            ((state == IDLE) && !hit && (WAIT_STATES == 0));
    assign array_read_en  = fill_now && fetch_in_range;
    assign array_write_en = load_fire && load_in_range;

    imem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock      (clock),
        .nReset     (nReset),
        .write_en   (array_write_en),
        .write_addr (load_word[ADDR_W-1:0]),
        .write_data (LoadData),
        .read_en    (array_read_en),
        .read_addr  (fetch_word[ADDR_W-1:0]),
        .read_data  (array_data)
    );

    // A fill in the same edge as a loader hit on the buffer wins, since it already
    // reads the freshly written word.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            cnt       <= '0;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_fault <= 1'b0;
            req_addr  <= '0;
        end else begin
            if (array_write_en && (buf_addr == load_word)) begin
                buf_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!hit) begin
                        req_addr <= fetch_word;
                        if (WAIT_STATES == 1) begin
                            state <= FILL;
                        end else if (WAIT_STATES > 1) begin
                            state <= WAIT;
                            cnt   <= WAIT_RELOAD;
                        end
                    end
                end
                WAIT: begin
                    if (fetch_word != req_addr) begin
                        req_addr <= fetch_word;
                        cnt      <= WAIT_RELOAD;
                    end else if (cnt == 4'd1) begin
                        state <= FILL;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                FILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (fill_now) begin
                buf_valid <= 1'b1;
                buf_addr  <= fetch_word;
                buf_fault <= !fetch_in_range;
            end
        end
    end

    assign IMemStall   = !hit;
    assign IMemFault   = buf_fault;
    assign IMemDataOut = buf_fault ? FAULT_WORD : array_data;
    assign LoadReady   = (state == IDLE);

endmodule
